// File: rtl/sram_read_requester.sv
// Read front end for a 2r1w SRAM: valid/ready requests in, ordered responses out,
// plus ownership of the write port for zeroing sweeps and external write pass-through.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_CLEAR | sweeping zeros over every address; requests and wr_* blocked
// ST_IDLE  | requests accepted, wr_* forwarded to the SRAM write port
module sram_read_requester #(
    parameter int DATA_WIDTH     = 32,
    parameter int SIZE           = 1024,
    parameter int ADDR_WIDTH     = (SIZE > 1) ? $clog2(SIZE) : 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    input  logic                  resp_ready,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  sram_read_en,
    output logic [ADDR_WIDTH-1:0] sram_read_addr,
    input  logic [DATA_WIDTH-1:0] sram_read_data,
    output logic                  sram_write_en,
    output logic [ADDR_WIDTH-1:0] sram_write_addr,
    output logic [DATA_WIDTH-1:0] sram_write_data
);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    localparam state_t                RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(SIZE - 1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clear_ptr;

    logic                    inflight;
    logic [1:0]              count;
    logic                    fifo_wr_ptr;
    logic                    fifo_rd_ptr;
    logic [DATA_WIDTH-1:0]   fifo_mem [2];

    logic                    rd_fire;
    logic                    push;
    logic                    pop_fifo;

    // Sweep stops exactly on the last valid address so non-power-of-two SIZE never overruns.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RESET_STATE;
            clear_ptr <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clear_ptr == LAST_ADDR) begin
                        state     <= ST_IDLE;
                        clear_ptr <= '0;
                    end else begin
                        clear_ptr <= clear_ptr + ADDR_WIDTH'(1);
                    end
                end
                ST_IDLE: begin
                    if (clear_start) begin
                        state <= ST_CLEAR;
                    end
                end
                default: state <= RESET_STATE;
            endcase
        end
    end

    assign clear_busy = (state == ST_CLEAR);

    always_comb begin
        sram_write_en   = wr_en;
        sram_write_addr = wr_addr;
        sram_write_data = wr_data;
        if (state == ST_CLEAR) begin
            sram_write_en   = 1'b1;
            sram_write_addr = clear_ptr;
            sram_write_data = '0;
        end
    end

    // Credit check counts the in-flight read so the 2-entry FIFO can never overflow.
    assign req_ready      = (state == ST_IDLE) && ((count + {1'b0, inflight}) < 2'd2);
    assign rd_fire        = req_valid && req_ready;
    assign sram_read_en   = rd_fire;
    assign sram_read_addr = req_addr;

    assign resp_valid = (count != 2'd0) || inflight;
    assign resp_data  = (count != 2'd0) ? fifo_mem[fifo_rd_ptr] : sram_read_data;

    // Returning data is parked unless it goes straight out through the bypass.
    assign pop_fifo = resp_ready && (count != 2'd0);
    assign push     = inflight && !((count == 2'd0) && resp_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight    <= 1'b0;
            count       <= 2'd0;
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
        end else begin
            inflight <= rd_fire;
            if (push) begin
                fifo_wr_ptr <= ~fifo_wr_ptr;
            end
            if (pop_fifo) begin
                fifo_rd_ptr <= ~fifo_rd_ptr;
            end
            case ({push, pop_fifo})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[fifo_wr_ptr] <= sram_read_data;
        end
    end

endmodule
